// File: rtl/kpw_reader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : kpw_reader                                               |
// | Description : Burst reader for the pointwise-kernel weight memory.     |
// |               Streams a run of words from a synchronous RAM into a     |
// |               2-entry registered FIFO feeding the PE-array interface.  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+

package ram_pkg;
  localparam int KPW_N_ELEM = 16;
endpackage

package dma_pkg;
  localparam int WG_W = 8;
  localparam int NPAR = 4;
endpackage

module kpw_reader #(
  parameter int KPW_N_ELEM = ram_pkg::KPW_N_ELEM,
  parameter int WG_W       = dma_pkg::WG_W,
  parameter int Npar       = dma_pkg::NPAR,
  localparam int W         = WG_W + $clog2(Npar),
  localparam int A         = $clog2(KPW_N_ELEM)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [A-1:0] base_addr,
  input  logic [A:0]   length,
  input  logic         abort,
  output logic [A-1:0] ram_addr,
  output logic         ram_write,
  output logic [W-1:0] ram_data,
  input  logic [W-1:0] ram_res,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  localparam logic [A-1:0] LAST_ADDR = A'(KPW_N_ELEM - 1);
  localparam logic [A:0]   ONE_WORD  = (A+1)'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [A-1:0]   ptr_q, ptr_d;
  logic [A:0]     icnt_q, icnt_d;
  logic [A:0]     dcnt_q, dcnt_d;
  logic           infl_q, infl_d;
  logic           done_q, done_d;
  logic [A-1:0]   addr_q;

  logic [W-1:0]   fifo_q [2];
  logic           rd_q;
  logic           wr_q;
  logic [1:0]     cnt_q;

  logic           pop;
  logic           push;
  logic           issue;
  logic [2:0]     level;

  // The block is read-only towards the weight memory.
  assign ram_write = 1'b0;
  assign ram_data  = '0;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = fifo_q[rd_q];
  assign busy      = (state_q == RUN);
  assign done      = done_q;

  assign pop  = out_valid & out_ready;
  // The word returned by the RAM lands in the FIFO one cycle after its issue.
  assign push = infl_q;

  // Slots already committed after this cycle's pop; the read issued now
  // needs one free slot when its data arrives next cycle.
  assign level = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
  assign issue = (state_q == RUN) && (icnt_q != '0) && (level < 3'd2)
                 && !abort && !reset;

  // Address is live during an issue and otherwise parks on the last value.
  assign ram_addr = issue ? ptr_q : addr_q;

  // Next-state logic for the burst controller and its counters.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    icnt_d  = icnt_q;
    dcnt_d  = dcnt_q;
    infl_d  = issue;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      icnt_d  = '0;
      dcnt_d  = '0;
      infl_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (length == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = RUN;
              ptr_d   = base_addr;
              icnt_d  = length;
              dcnt_d  = length;
            end
          end
        end
        RUN: begin
          if (issue) begin
            ptr_d  = (ptr_q == LAST_ADDR) ? '0 : ptr_q + 1'b1;
            icnt_d = icnt_q - ONE_WORD;
          end
          if (pop) begin
            dcnt_d = dcnt_q - ONE_WORD;
            if (dcnt_q == ONE_WORD) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Controller state, counters, in-flight flag and parked address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      icnt_q  <= '0;
      dcnt_q  <= '0;
      infl_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      icnt_q  <= icnt_d;
      dcnt_q  <= dcnt_d;
      infl_q  <= infl_d;
      done_q  <= done_d;
      addr_q  <= ram_addr;
    end
  end

  // Two-entry output FIFO; abort drops its contents and any in-flight word.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      cnt_q     <= 2'd0;
    end else if (abort) begin
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_q] <= ram_res;
        wr_q         <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_kpw_reader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_kpw_reader                                            |
// | Description : Scoreboard bench for kpw_reader with a synchronous RAM   |
// |               model and directed burst scenarios.                      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_kpw_reader;

  localparam int N  = 16;
  localparam int WG = 8;
  localparam int NP = 4;
  localparam int W  = WG + $clog2(NP);
  localparam int A  = $clog2(N);

  logic         clk;
  logic         reset;
  logic         start;
  logic [A-1:0] base_addr;
  logic [A:0]   length;
  logic         abort;
  logic [A-1:0] ram_addr;
  logic         ram_write;
  logic [W-1:0] ram_data;
  logic [W-1:0] ram_res;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_pass   = 0;
  int pops     = 0;
  logic [W-1:0] exp_q[$];

  kpw_reader #(.KPW_N_ELEM(N), .WG_W(WG), .Npar(NP)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .abort(abort), .ram_addr(ram_addr),
    .ram_write(ram_write), .ram_data(ram_data), .ram_res(ram_res),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of the weight memory as seen by the bench.
  function automatic logic [W-1:0] memf(input logic [A-1:0] a);
    return W'(a) * W'(7) + W'(100);
  endfunction

  // Synchronous RAM: data valid one cycle after the address.
  always @(posedge clk) ram_res <= memf(ram_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pop expected words on every handshake, and check hold during stalls.
  logic         stall_prev = 1'b0;
  logic [W-1:0] stall_data = '0;
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(stall_data));
      end
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) chk("unexpected_pop", 32'(out_data), 32'hFFFF_FFFF);
        else chk("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
      stall_prev = out_valid && !out_ready && !abort;
      stall_data = out_data;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input int b, input int len, input bit expect_words);
    base_addr = A'(b);
    length    = (A+1)'(len);
    start     = 1'b1;
    if (expect_words)
      for (int i = 0; i < len; i++) exp_q.push_back(memf(A'(b + i)));
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int k = 0; k < 60; k++) begin
      cyc();
      #1;
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk(name, 32'(seen), 32'd1);
    chk({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    bit seen;
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    base_addr = '0; length = '0;
    repeat (3) cyc();
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("ram_write", 32'(ram_write), 32'd0);
    chk("ram_data", 32'(ram_data), 32'd0);
    cyc();
    reset = 1'b0;
    cyc();

    // Basic burst: base 4, length 3, cycle-exact timing.
    start_burst(4, 3, 1);
    cyc(); start = 1'b0; #1;                               // cycle 1
    chk("b1_busy", 32'(busy), 32'd1);
    chk("b1_addr_c1", 32'(ram_addr), 32'd4);
    chk("b1_valid_c1", 32'(out_valid), 32'd0);
    cyc(); #1;                                             // cycle 2
    chk("b1_addr_c2", 32'(ram_addr), 32'd5);
    chk("b1_valid_c2", 32'(out_valid), 32'd0);
    cyc(); #1;                                             // cycle 3
    chk("b1_addr_c3", 32'(ram_addr), 32'd6);
    chk("b1_valid_c3", 32'(out_valid), 32'd1);
    chk("b1_data_c3", 32'(out_data), 32'(memf(4'd4)));
    cyc(); #1;                                             // cycle 4
    chk("b1_addr_hold", 32'(ram_addr), 32'd6);
    chk("b1_valid_c4", 32'(out_valid), 32'd1);
    cyc(); #1;                                             // cycle 5
    chk("b1_valid_c5", 32'(out_valid), 32'd1);
    chk("b1_done_c5", 32'(done), 32'd0);
    cyc(); #1;                                             // cycle 6
    chk("b1_done_c6", 32'(done), 32'd1);
    chk("b1_busy_c6", 32'(busy), 32'd0);
    chk("b1_valid_c6", 32'(out_valid), 32'd0);
    cyc(); #1;
    chk("b1_done_c7", 32'(done), 32'd0);

    // Zero-length burst.
    start_burst(9, 0, 0);
    cyc(); start = 1'b0; #1;
    chk("z_done", 32'(done), 32'd1);
    chk("z_busy", 32'(busy), 32'd0);
    chk("z_addr", 32'(ram_addr), 32'd6);
    cyc(); #1;
    chk("z_done_pulse", 32'(done), 32'd0);

    // Address wrap at the top of memory.
    start_burst(N - 2, 4, 1);
    cyc(); start = 1'b0; #1;
    chk("wrap_a0", 32'(ram_addr), 32'(N - 2));
    cyc(); #1;
    chk("wrap_a1", 32'(ram_addr), 32'(N - 1));
    cyc(); #1;
    chk("wrap_a2", 32'(ram_addr), 32'd0);
    cyc(); #1;
    chk("wrap_a3", 32'(ram_addr), 32'd1);
    wait_done("wrap_done");
    cyc();

    // Second start during RUN is ignored.
    p0 = pops;
    start_burst(3, 5, 1);
    cyc(); start = 1'b0;
    cyc(); start_burst(10, 2, 0);
    cyc(); start = 1'b0;
    wait_done("restart_done");
    chk("restart_pops", 32'(pops - p0), 32'd5);
    repeat (4) cyc();
    chk("restart_idle", 32'(busy), 32'd0);

    // Abort at cycle 4 of a length-10 burst, then a fresh burst.
    start_burst(0, 10, 1);
    cyc(); start = 1'b0;
    cyc(); cyc(); cyc();                                   // cycle 4
    abort = 1'b1;
    cyc(); abort = 1'b0; #1;                               // cycle 5
    exp_q.delete();
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done5", 32'(done), 32'd0);
    cyc(); #1;                                             // cycle 6
    chk("abort_done6", 32'(done), 32'd0);
    start_burst(5, 2, 1);
    cyc(); start = 1'b0;
    wait_done("post_abort_done");

    // Abort and start together in IDLE: start is dropped.
    cyc();
    start_burst(1, 3, 0);
    abort = 1'b1;
    cyc(); start = 1'b0; abort = 1'b0; #1;
    chk("abst_busy", 32'(busy), 32'd0);
    cyc(); #1;
    chk("abst_valid", 32'(out_valid), 32'd0);

    // Reset mid-burst, together with start and abort.
    start_burst(0, 6, 1);
    cyc(); start = 1'b0;
    cyc(); cyc();                                          // cycle 3
    reset = 1'b1; start = 1'b1; abort = 1'b1;
    cyc(); reset = 1'b0; start = 1'b0; abort = 1'b0; #1;
    exp_q.delete();
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_addr", 32'(ram_addr), 32'd0);
    chk("mrst_data", 32'(out_data), 32'd0);
    cyc(); #1;
    chk("mrst_done", 32'(done), 32'd0);

    // Back-pressure: out_ready toggles 1,0,0,1,0,0,...
    p0 = pops;
    start_burst(2, 8, 1);
    cyc(); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      out_ready = (i % 3 == 0);
      #1;
      if (done) begin
        seen = 1;
        break;
      end
      cyc();
    end
    out_ready = 1'b1;
    chk("stall_done", 32'(seen), 32'd1);
    chk("stall_pops", 32'(pops - p0), 32'd8);

    repeat (3) cyc();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/kpw_reader.md
KPW_READER -- requirements
Module: kpw_reader

Interface
REQ-001 The block SHALL take parameter KPW_N_ELEM, default from ram_pkg, meaning the depth of the pointwise-kernel weight memory in words.
REQ-002 The block SHALL take parameter WG_W, default from dma_pkg, meaning the weight width in bits.
REQ-003 The block SHALL take parameter Npar, default from dma_pkg, meaning the parallelism factor; word width W = WG_W + $clog2(Npar); address width A = $clog2(KPW_N_ELEM).
REQ-004 The block SHALL have port clk, input, 1 bit, the only clock.
REQ-005 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit, a one-cycle request to begin a burst.
REQ-007 The block SHALL have port base_addr, input, A bits, the first word address, sampled with start.
REQ-008 The block SHALL have port length, input, A+1 bits, the number of words (0..KPW_N_ELEM), sampled with start.
REQ-009 The block SHALL have port abort, input, 1 bit, which flushes the burst.
REQ-010 The block SHALL have ports ram_addr (output, A bits), ram_write (output, 1 bit), and ram_data (output, W bits), which drive the weight memory port.
REQ-011 The block SHALL have port ram_res, input, W bits, the memory read data, valid one cycle after the address.
REQ-012 The block SHALL have ports out_data (output, W bits), out_valid (output, 1 bit), and out_ready (input, 1 bit), the weight stream to the PE array.
REQ-013 The block SHALL have ports busy (output, 1 bit) and done (output, 1 bit, one-cycle pulse).

Function
REQ-014 ram_write and ram_data SHALL be constant 0; the block never writes the memory.
REQ-015 The FSM SHALL have the states IDLE and RUN; start is accepted only in IDLE, and start in RUN is ignored.
REQ-016 When start is accepted with length=0, the FSM SHALL stay in IDLE, pulse done in the next cycle, and keep busy low.
REQ-017 When start is accepted with length>0, the FSM SHALL enter RUN next cycle with busy=1, issue pointer = base_addr, issue count = length, and deliver count = length.
REQ-018 The block SHALL contain a 2-entry output FIFO; a read is issued in a cycle iff RUN, issue count>0, and occupancy + in-flight - pop < 2, where pop = out_valid & out_ready.
REQ-019 On an issue, the block SHALL drive ram_addr with the issue pointer, then increment the pointer with wrap from KPW_N_ELEM-1 to 0 and decrement the issue count.
REQ-020 ram_res SHALL be written into the FIFO in the cycle after the issue; in-flight depth is at most 1.
REQ-021 out_valid SHALL equal FIFO non-empty, out_data SHALL be the FIFO head, and both SHALL be registered (no combinational path from ram_res).
REQ-022 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 Each pop SHALL decrement the deliver count; on the pop that takes it to 0, the FSM SHALL return to IDLE and done SHALL pulse in the following cycle, with busy low in that cycle.
REQ-024 Latency: with start sampled at cycle 0 and out_ready=1, the first read SHALL be issued at cycle 1, out_valid SHALL rise at cycle 3, and one word per cycle SHALL be delivered thereafter.
REQ-025 When ram_addr is not issuing, it SHALL hold its last value.
REQ-026 abort SHALL take priority over all other inputs: next cycle state = IDLE, FIFO empty, any in-flight result discarded, counts cleared, and no done pulse.
REQ-027 If abort and start are asserted in the same cycle, the start SHALL be ignored.

Reset
REQ-028 While reset=1 at a clock edge, the block SHALL drive state=IDLE, FIFO empty, in-flight=0, out_valid=0, out_data=0, busy=0, done=0, ram_addr=0, and counts=0.
REQ-029 reset asserted mid-burst SHALL behave as abort, with reset also taking priority over abort and start.

Verification
REQ-030 Scenario: base_addr=4, length=3, out_ready=1 -> ram_addr 4,5,6 at cycles 1..3; out_valid cycles 3..5 carrying mem[4..6]; done at cycle 6.
REQ-031 Scenario: base_addr=KPW_N_ELEM-2, length=4 -> addresses KPW_N_ELEM-2, KPW_N_ELEM-1, 0, 1 in order, with 4 words delivered.
REQ-032 Scenario: length=8 with out_ready toggling 1,0,0,1,... -> exactly 8 pops in address order, no drop or duplicate, out_data stable while stalled, and occupancy never above 2.
REQ-033 Scenario: length=0 -> done pulses at cycle 1, busy stays 0, and no address is issued.
REQ-034 Scenario: abort at cycle 4 of a length=10 burst -> out_valid=0 at cycle 5, no done pulse, and a new start at cycle 6 runs normally.
REQ-035 Scenario: start pulsed again during RUN with different base_addr and length -> the second start is ignored and the original burst completes unchanged.
